// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic processing element.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } pe_state_t;

    localparam logic MODE_FLOW = 1'b0;
    localparam logic MODE_OS   = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;

endpackage

// File: rtl/pe_acc_add.sv
// ACC_W adder shared by the accumulator and base_out paths.
// SYSTOLIC_PE_SAT_EN selects saturating arithmetic; otherwise the sum wraps and ovf_o is 0.
module pe_acc_add #(
    parameter int ACC_W  = 24,
    parameter bit SIGNED = 1'b0
) (
    input  logic [ACC_W-1:0] op_a_i,
    input  logic [ACC_W-1:0] op_b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

`ifdef SYSTOLIC_PE_SAT_EN
    logic [ACC_W:0]   raw_s;
    logic [ACC_W-1:0] sat_s;
    logic             clip_s;

    assign raw_s = {1'b0, op_a_i} + {1'b0, op_b_i};

    // Clip to the representable range when the true sum leaves it.
    always_comb begin
        sat_s  = raw_s[ACC_W-1:0];
        clip_s = 1'b0;
        if (SIGNED) begin
            if ((op_a_i[ACC_W-1] == op_b_i[ACC_W-1]) &&
                (raw_s[ACC_W-1] != op_a_i[ACC_W-1])) begin
                clip_s = 1'b1;
                sat_s  = op_a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                clip_s = 1'b0;
            end
        end else begin
            if (raw_s[ACC_W]) begin
                clip_s = 1'b1;
                sat_s  = {ACC_W{1'b1}};
            end else begin
                clip_s = 1'b0;
            end
        end
    end

    assign sum_o = sat_s;
    assign ovf_o = clip_s;
`else
    assign sum_o = op_a_i + op_b_i;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/systolic_pe.sv
// Systolic matrix-multiply processing element with FLOW and OUTPUT-STATIONARY dataflow.
// SYSTOLIC_PE_SAT_EN enables saturating adds and the sticky ovf flag.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] wt_in,
    input  logic [ACC_W-1:0]  base_in,
    input  logic              base_valid_in,
    input  logic              acc_clr,
    input  logic              drain,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] wt_out,
    output logic              out_valid,
    output logic [ACC_W-1:0]  base_out,
    output logic              base_valid,
    output logic              busy,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;

    generate
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("systolic_pe: ACC_W must be >= 2*DATA_W");
        end
    endgenerate

    pe_state_t         state_q, state_d;
    logic              mode_q, mode_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  base_out_q, base_out_d;
    logic              base_valid_q, base_valid_d;
    logic              seen_q, seen_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] a_out_q, wt_out_q;
    logic              out_valid_q;

    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  p_s;
    logic [ACC_W-1:0]  acc_base_s;
    logic [ACC_W-1:0]  acc_sum_s, flow_sum_s;
    logic              acc_clip_s, flow_clip_s, clip_s;

    generate
        if (SIGNED) begin : g_signed
            logic signed [PROD_W-1:0] sprod_s;
            assign sprod_s    = $signed(a_in) * $signed(wt_in);
            assign prod_ext_s = ACC_W'(sprod_s);
        end else begin : g_unsigned
            logic [PROD_W-1:0] uprod_s;
            assign uprod_s    = a_in * wt_in;
            assign prod_ext_s = ACC_W'(uprod_s);
        end
    endgenerate

    assign p_s        = in_valid ? prod_ext_s : {ACC_W{1'b0}};
    assign acc_base_s = acc_clr ? {ACC_W{1'b0}} : acc_q;

    pe_acc_add #(.ACC_W(ACC_W), .SIGNED(SIGNED)) u_acc_add (
        .op_a_i (acc_base_s),
        .op_b_i (p_s),
        .sum_o  (acc_sum_s),
        .ovf_o  (acc_clip_s)
    );

    pe_acc_add #(.ACC_W(ACC_W), .SIGNED(SIGNED)) u_base_add (
        .op_a_i (base_in),
        .op_b_i (p_s),
        .sum_o  (flow_sum_s),
        .ovf_o  (flow_clip_s)
    );

    // Next-state logic for the dataflow FSM, accumulator and base chain.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        base_out_d   = base_out_q;
        base_valid_d = base_valid_q;
        seen_d       = seen_q;
        clip_s       = 1'b0;

        if (state_q == IDLE) begin
            mode_d = mode;
        end else begin
            mode_d = mode_q;
        end

        if (mode_q == MODE_FLOW) begin
            base_out_d   = flow_sum_s;
            base_valid_d = in_valid | base_valid_in;
            clip_s       = flow_clip_s;
            case (state_q)
                IDLE, ACCUM: state_d = in_valid ? ACCUM : IDLE;
                default:     state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    clip_s = acc_clip_s;
                    if (drain) begin
                        base_out_d   = acc_sum_s;
                        base_valid_d = 1'b1;
                        acc_d        = {ACC_W{1'b0}};
                        seen_d       = 1'b0;
                        state_d      = DRAIN;
                    end else begin
                        acc_d        = acc_sum_s;
                        base_valid_d = 1'b0;
                        state_d      = in_valid ? ACCUM : state_q;
                    end
                end
                DRAIN: begin
                    // Pass the results of PEs above through while the next tile starts.
                    base_out_d   = base_in;
                    base_valid_d = base_valid_in;
                    acc_d        = acc_sum_s;
                    clip_s       = acc_clip_s;
                    seen_d       = seen_q | in_valid;
                    if (drain) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = seen_d ? ACCUM : IDLE;
                    end
                end
                default: begin
                    base_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            endcase
        end

        ovf_d = (acc_clr ? 1'b0 : ovf_q) | clip_s;
    end

    // State and output registers; synchronous reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= MODE_FLOW;
            acc_q        <= {ACC_W{1'b0}};
            base_out_q   <= {ACC_W{1'b0}};
            base_valid_q <= 1'b0;
            seen_q       <= 1'b0;
            ovf_q        <= 1'b0;
            a_out_q      <= {DATA_W{1'b0}};
            wt_out_q     <= {DATA_W{1'b0}};
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            base_out_q   <= base_out_d;
            base_valid_q <= base_valid_d;
            seen_q       <= seen_d;
            ovf_q        <= ovf_d;
            a_out_q      <= a_in;
            wt_out_q     <= wt_in;
            out_valid_q  <= in_valid;
        end
    end

    assign a_out      = a_out_q;
    assign wt_out     = wt_out_q;
    assign out_valid  = out_valid_q;
    assign base_out   = base_out_q;
    assign base_valid = base_valid_q;
    assign busy       = (state_q != IDLE);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe (default unsigned build plus a SIGNED, ACC_W=16 instance).
module tb_systolic_pe;

`ifdef SYSTOLIC_PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        mode, in_valid, base_valid_in, acc_clr, drain;
    logic [7:0]  a_in, wt_in;
    logic [23:0] base_in;

    logic [7:0]  a_out, wt_out;
    logic        out_valid, base_valid, busy, ovf;
    logic [23:0] base_out;

    logic [7:0]  a_out_s, wt_out_s;
    logic        out_valid_s, base_valid_s, busy_s, ovf_s;
    logic [15:0] base_out_s;

    int n_assert = 0;
    int n_fail   = 0;

    systolic_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b0)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
        .a_in(a_in), .wt_in(wt_in), .base_in(base_in), .base_valid_in(base_valid_in),
        .acc_clr(acc_clr), .drain(drain), .a_out(a_out), .wt_out(wt_out),
        .out_valid(out_valid), .base_out(base_out), .base_valid(base_valid),
        .busy(busy), .ovf(ovf)
    );

    systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
        .a_in(a_in), .wt_in(wt_in), .base_in(base_in[15:0]), .base_valid_in(base_valid_in),
        .acc_clr(acc_clr), .drain(drain), .a_out(a_out_s), .wt_out(wt_out_s),
        .out_valid(out_valid_s), .base_out(base_out_s), .base_valid(base_valid_s),
        .busy(busy_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] a, input logic [7:0] w,
                         input logic [23:0] b, input logic bv, input logic clr, input logic dr);
        in_valid      = iv;
        a_in          = a;
        wt_in         = w;
        base_in       = b;
        base_valid_in = bv;
        acc_clr       = clr;
        drain         = dr;
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_base_out", 32'(base_out), 32'd0);
        check("rst_base_valid", 32'(base_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;

        // FLOW: 100 + 3*4
        drive(1'b1, 8'd3, 8'd4, 24'd100, 1'b0, 1'b0, 1'b0);
        step();
        check("flow_base_out", 32'(base_out), 32'd112);
        check("flow_base_valid", 32'(base_valid), 32'd1);
        check("flow_a_out", 32'(a_out), 32'd3);
        check("flow_wt_out", 32'(wt_out), 32'd4);
        check("flow_out_valid", 32'(out_valid), 32'd1);
        check("flow_busy", 32'(busy), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd5, 1'b1, 1'b0, 1'b0);
        step();
        check("flow_pass_base", 32'(base_out), 32'd5);
        check("flow_pass_valid", 32'(base_valid), 32'd1);
        check("flow_pass_outv", 32'(out_valid), 32'd0);
        check("flow_idle_busy", 32'(busy), 32'd0);

        // FLOW boundary: all-ones base plus 1
        drive(1'b1, 8'd1, 8'd1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        step();
        check("flow_edge_base", 32'(base_out), SAT ? 32'h00FFFFFF : 32'd0);
        check("flow_edge_ovf", 32'(ovf), SAT ? 32'd1 : 32'd0);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("flow_ovf_clr", 32'(ovf), 32'd0);
        check("flow_edge_busy", 32'(busy), 32'd0);

        // mode raised while busy: stays FLOW until back in IDLE
        drive(1'b1, 8'd2, 8'd3, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("mt_first", 32'(base_out), 32'd6);
        mode = 1'b1;
        drive(1'b1, 8'd1, 8'd1, 24'd10, 1'b0, 1'b0, 1'b0);
        step();
        check("mt_still_flow", 32'(base_out), 32'd11);
        check("mt_still_flow_v", 32'(base_valid), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("mt_idle", 32'(busy), 32'd0);
        step();
        drive(1'b1, 8'd4, 8'd5, 24'd77, 1'b1, 1'b1, 1'b0);
        step();
        check("mt_os_accum_v", 32'(base_valid), 32'd0);
        check("mt_os_busy", 32'(busy), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd77, 1'b0, 1'b0, 1'b1);
        step();
        check("mt_os_drain", 32'(base_out), 32'd20);
        check("mt_os_drain_v", 32'(base_valid), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd77, 1'b0, 1'b0, 1'b0);
        step();
        check("mt_os_pass", 32'(base_out), 32'd77);
        check("mt_os_pass_v", 32'(base_valid), 32'd0);
        check("mt_os_idle", 32'(busy), 32'd0);

        // OS: 2*5 + 3*7 + 1*1 = 32, then drain and pass-through
        drive(1'b1, 8'd2, 8'd5, 24'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'd3, 8'd7, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'd1, 8'd1, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("os_accum_v", 32'(base_valid), 32'd0);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("os_drain_32", 32'(base_out), 32'd32);
        check("os_drain_32_v", 32'(base_valid), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd9, 1'b1, 1'b0, 1'b1);
        step();
        check("os_chain_9", 32'(base_out), 32'd9);
        check("os_chain_9_v", 32'(base_valid), 32'd1);
        check("os_chain_busy", 32'(busy), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd9, 1'b0, 1'b0, 1'b0);
        step();
        check("os_end_v", 32'(base_valid), 32'd0);
        check("os_end_idle", 32'(busy), 32'd0);

        // OS: drain with in_valid in the same cycle, then a tile overlapping the drain
        drive(1'b1, 8'd2, 8'd5, 24'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'd2, 8'd2, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("os_drain_14", 32'(base_out), 32'd14);
        drive(1'b1, 8'd3, 8'd3, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("os_overlap_v", 32'(base_valid), 32'd0);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("os_to_accum", 32'(busy), 32'd1);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("os_acc_cleared", 32'(base_out), 32'd9);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("os_back_idle", 32'(busy), 32'd0);

        // reset mid-drain with base_valid high
        drive(1'b1, 8'd1, 8'd1, 24'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("md_valid", 32'(base_valid), 32'd1);
        mode  = 1'b0;
        reset = 1'b1;
        drive(1'b1, 8'd7, 8'd7, 24'd55, 1'b1, 1'b0, 1'b1);
        step();
        check("md_base_out", 32'(base_out), 32'd0);
        check("md_base_valid", 32'(base_valid), 32'd0);
        check("md_a_out", 32'(a_out), 32'd0);
        check("md_out_valid", 32'(out_valid), 32'd0);
        check("md_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 24'd3, 1'b1, 1'b0, 1'b0);
        step();
        check("md_flow_after", 32'(base_out), 32'd3);
        check("md_flow_after_v", 32'(base_valid), 32'd1);

        // signed instance: (-128)*(-128) accumulated into 16 bits
        reset = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        mode  = 1'b1;
        step();
        drive(1'b1, 8'h80, 8'h80, 24'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("s_ovf0", 32'(ovf_s), 32'd0);
        drive(1'b1, 8'h80, 8'h80, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("s_ovf1", 32'(ovf_s), SAT ? 32'd1 : 32'd0);
        step();
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("s_clip", 32'(base_out_s), SAT ? 32'h7FFF : 32'hC000);
        check("s_clip_v", 32'(base_valid_s), 32'd1);
        check("s_ovf_sticky", 32'(ovf_s), SAT ? 32'd1 : 32'd0);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("s_idle", 32'(busy_s), 32'd0);
        drive(1'b1, 8'hFE, 8'h03, 24'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("s_ovf_clr", 32'(ovf_s), 32'd0);
        drive(1'b0, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("s_neg6", 32'(base_out_s), 32'h0000FFFA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
